// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: arbitration state and port identifier.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one single-port memory: round-robin between a core port and a
// debug/loader port, with a bounded locked burst mode for port 1 and one-cycle read return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    arb_state_t       r_state;
    port_id_t         r_last_owner;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_p0_rvalid;
    logic             r_p1_rvalid;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    arb_state_t w_next_state;
    logic       w_lock_hold;
    logic       w_p0_gnt;
    logic       w_p1_gnt;

    // Lock only extends a run that port 1 already owns in the immediately preceding cycle.
    always_comb begin
        w_next_state = IDLE;
        w_lock_hold  = (r_state == GNT1) && p1_lock && p1_req && (r_burst_cnt < BURST_LIMIT);
        if (!reset) begin
            w_next_state = IDLE;
        end else if (w_lock_hold) begin
            w_next_state = GNT1;
        end else if (p0_req && p1_req) begin
            w_next_state = (r_last_owner == PORT1) ? GNT0 : GNT1;
        end else if (p0_req) begin
            w_next_state = GNT0;
        end else if (p1_req) begin
            w_next_state = GNT1;
        end
    end

    assign w_p0_gnt = (w_next_state == GNT0);
    assign w_p1_gnt = (w_next_state == GNT1);
    assign p0_gnt   = w_p0_gnt;
    assign p1_gnt   = w_p1_gnt;

    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        case (w_next_state)
            GNT0: begin
                mem_a  = p0_addr;
                mem_wd = p0_wdata;
                mem_we = p0_we;
            end
            GNT1: begin
                mem_a  = p1_addr;
                mem_wd = p1_wdata;
                mem_we = p1_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_owner <= PORT1;
            r_burst_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            case (w_next_state)
                GNT0: begin
                    r_last_owner <= PORT0;
                    r_burst_cnt  <= '0;
                end
                GNT1: begin
                    r_last_owner <= PORT1;
                    if (r_burst_cnt != BURST_LIMIT) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_burst_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_p0_gnt && !p0_we;
            r_p1_rvalid <= w_p1_gnt && !p1_we;
            if (w_p0_gnt && !p0_we) begin
                r_p0_rdata <= mem_rd;
            end
            if (w_p1_gnt && !p1_we) begin
                r_p1_rdata <= mem_rd;
            end
        end
    end

    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks check grants and the memory bus inline,
// and a negedge monitor compares read returns against a queue of expected data.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [256];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic        pend0 = 1'b0, pend1 = 1'b0;
    logic [31:0] last0 = '0, last1 = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_a[31:8] == 24'd0) ? mem[mem_a[7:0]] : 32'd0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= {24'hC0FFEE, i[7:0]};
        mem[8'h10] <= 32'hDEADBEEF;
    end

    always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

    always @(negedge reset) begin
        pend0 = 1'b0; pend1 = 1'b0; last0 = '0; last1 = '0;
    end

    // Read-return monitor: rvalid must follow a read grant by one cycle, rdata must hold otherwise.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            total++;
            if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
                bad++; $display("FAIL rvalid_in_reset: got %b want 00", {p0_rvalid, p1_rvalid});
            end
            total++;
            if ({p0_rdata, p1_rdata} !== 64'd0) begin
                bad++; $display("FAIL rdata_in_reset: got %h %h want 0", p0_rdata, p1_rdata);
            end
        end else begin
            total++;
            if (p0_rvalid !== pend0) begin
                bad++; $display("FAIL p0_rvalid: got %b want %b", p0_rvalid, pend0);
            end
            total++;
            if (pend0) begin
                if (exp0.size() == 0) begin
                    bad++; $display("FAIL p0_rdata: no expected read queued");
                end else begin
                    e = exp0.pop_front();
                    if (p0_rdata !== e) begin
                        bad++; $display("FAIL p0_rdata: got %h want %h", p0_rdata, e);
                    end
                    last0 = e;
                end
            end else if (p0_rdata !== last0) begin
                bad++; $display("FAIL p0_rdata_hold: got %h want %h", p0_rdata, last0);
            end
            total++;
            if (p1_rvalid !== pend1) begin
                bad++; $display("FAIL p1_rvalid: got %b want %b", p1_rvalid, pend1);
            end
            total++;
            if (pend1) begin
                if (exp1.size() == 0) begin
                    bad++; $display("FAIL p1_rdata: no expected read queued");
                end else begin
                    e = exp1.pop_front();
                    if (p1_rdata !== e) begin
                        bad++; $display("FAIL p1_rdata: got %h want %h", p1_rdata, e);
                    end
                    last1 = e;
                end
            end else if (p1_rdata !== last1) begin
                bad++; $display("FAIL p1_rdata_hold: got %h want %h", p1_rdata, last1);
            end
            pend0 = (p0_gnt === 1'b1) && (p0_we === 1'b0);
            pend1 = (p1_gnt === 1'b1) && (p1_we === 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_lock = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h60; p1_wdata = 32'h1;
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt, mem_we} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs: got gnt/we %b want 000", {p0_gnt, p1_gnt, mem_we});
        end
        tick();
        reset = 1'b1;
        exp0.push_back(32'hDEADBEEF);
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            bad++; $display("FAIL first_after_reset: got %b want 10", {p0_gnt, p1_gnt});
        end
        tick();
        idle_inputs();
        @(negedge clk);
        tick();
    endtask

    task automatic test_single_read();
        p0_req = 1'b1; p0_addr = 32'h10;
        exp0.push_back(32'hDEADBEEF);
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt, mem_we} !== 3'b100 || mem_a !== 32'h10) begin
            bad++; $display("FAIL single_read: got gnt/we %b a %h want 100 a 10",
                            {p0_gnt, p1_gnt, mem_we}, mem_a);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        p0_req = 1'b1; p0_addr = 32'h30;
        p1_req = 1'b1; p1_addr = 32'h31;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp0.push_back(32'hC0FFEE30);
            else            exp1.push_back(32'hC0FFEE31);
            @(negedge clk);
            total++;
            if ({p0_gnt, p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL round_robin[%0d]: got %b", i, {p0_gnt, p1_gnt});
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        tick();
    endtask

    task automatic test_lock_burst();
        logic [6:0] pat;
        pat = 7'b1011110;  // bit i: 1 = port 1 expected in cycle i
        apply_reset();
        p1_lock = 1'b1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'h4040;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h41; p1_wdata = 32'h4141;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            total++;
            if ({p0_gnt, p1_gnt} !== {!pat[i], pat[i]} ||
                mem_wd !== (pat[i] ? 32'h4141 : 32'h4040) || mem_we !== 1'b1) begin
                bad++; $display("FAIL lock_burst[%0d]: got gnt %b wd %h want p1=%b",
                                i, {p0_gnt, p1_gnt}, mem_wd, pat[i]);
            end
            tick();
        end
        // p1 alone keeps winning past the limit; the saturated count then yields to p0.
        p0_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({p0_gnt, p1_gnt} !== 2'b01) begin
                bad++; $display("FAIL lock_alone[%0d]: got %b want 01", i, {p0_gnt, p1_gnt});
            end
            tick();
        end
        p0_req = 1'b1;
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            bad++; $display("FAIL lock_saturated: got %b want 10", {p0_gnt, p1_gnt});
        end
        tick();
        idle_inputs();
        total++;
        if (mem[8'h41] !== 32'h4141 || mem[8'h40] !== 32'h4040) begin
            bad++; $display("FAIL lock_writes: got %h %h want 4040 4141", mem[8'h40], mem[8'h41]);
        end
        @(negedge clk);
        tick();
    endtask

    task automatic test_back_to_back();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h55;
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt, mem_we} !== 3'b011 || mem_a !== 32'h20 || mem_wd !== 32'h55) begin
            bad++; $display("FAIL raw_write: got gnt/we %b a %h wd %h want 011 a 20 wd 55",
                            {p0_gnt, p1_gnt, mem_we}, mem_a, mem_wd);
        end
        tick();
        idle_inputs();
        p0_req = 1'b1; p0_addr = 32'h20;
        exp0.push_back(32'h55);
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            bad++; $display("FAIL raw_read_gnt: got %b want 10", {p0_gnt, p1_gnt});
        end
        tick();
        p0_we = 1'b1; p0_addr = 32'h24; p0_wdata = 32'h66;
        @(negedge clk);
        total++;
        if ({p0_gnt, mem_we} !== 2'b11) begin
            bad++; $display("FAIL b2b_write: got gnt/we %b want 11", {p0_gnt, mem_we});
        end
        tick();
        p0_we = 1'b0; p0_wdata = '0;
        exp0.push_back(32'h66);
        @(negedge clk);
        tick();
        idle_inputs();
        @(negedge clk);
        tick();
    endtask

    task automatic test_withdraw();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h70; p1_wdata = 32'h77;
        @(negedge clk);
        tick();
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_addr = 32'h50; p1_wdata = 32'hBAD;
        exp0.push_back(32'hDEADBEEF);
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt, mem_we} !== 3'b100 || mem_a !== 32'h10) begin
            bad++; $display("FAIL withdraw_contend: got gnt/we %b a %h want 100 a 10",
                            {p0_gnt, p1_gnt, mem_we}, mem_a);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if ({p1_gnt, mem_we} !== 2'b00) begin
            bad++; $display("FAIL withdraw_drop: got gnt/we %b want 00", {p1_gnt, mem_we});
        end
        tick();
        total++;
        if (mem[8'h50] !== 32'hC0FFEE50) begin
            bad++; $display("FAIL withdraw_mem: got %h want c0ffee50", mem[8'h50]);
        end
    endtask

    task automatic test_reset_mid_read();
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h60; p1_wdata = 32'h1234;
        #1;
        reset = 1'b0;
        #1;
        total++;
        if ({p0_gnt, p1_gnt, mem_we} !== 3'b000) begin
            bad++; $display("FAIL mid_reset_outputs: got gnt/we %b want 000",
                            {p0_gnt, p1_gnt, mem_we});
        end
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        p1_we = 1'b0;
        reset = 1'b1;
        exp0.push_back(32'hDEADBEEF);
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            bad++; $display("FAIL mid_reset_release: got %b want 10", {p0_gnt, p1_gnt});
        end
        tick();
        idle_inputs();
        @(negedge clk);
        tick();
        total++;
        if (mem[8'h60] !== 32'hC0FFEE60) begin
            bad++; $display("FAIL mid_reset_mem: got %h want c0ffee60", mem[8'h60]);
        end
    endtask

    initial begin
        #1;
        reset = 1'b0;
        tick();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_back_to_back();
        test_withdraw();
        test_reset_mid_read();
        tick();
        total++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0",
                            exp0.size(), exp1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; MAX_BURST, default 4, max consecutive locked grants to port 1.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, as name direction width meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous active-low reset
- p0_req  in  1  core port request
- p0_we  in  1  core write enable
- p0_addr  in  ADDR_W  core address
- p0_wdata  in  DATA_W  core write data
- p0_gnt  out  1  core access performed this cycle
- p0_rvalid  out  1  core read data valid
- p0_rdata  out  DATA_W  core read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  as port 0, for the debug/loader port
- p1_lock  in  1  port 1 requests back-to-back grants
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DATA_W  memory combinational read data

Function
REQ-004 The module SHALL share one single-port memory (combinational read, write on clk rising edge when mem_we=1) between ports 0 and 1.
REQ-005 The FSM SHALL have states IDLE, GNT0, GNT1; the state is the combinational grant decision registered as last_owner.
REQ-006 Each cycle at most one of p0_gnt/p1_gnt SHALL be 1; gnt is combinational from req and arbitration state.
REQ-007 Only one requester: it SHALL be granted in the same cycle.
REQ-008 Both requesting, lock inactive: grant SHALL alternate round-robin; the port not served last wins; after reset port 0 wins first.
REQ-009 If last grant went to port 1, p1_lock=1, p1_req=1 and burst_cnt < MAX_BURST, port 1 SHALL be granted regardless of p0_req.
REQ-010 burst_cnt SHALL increment on each consecutive port-1 grant, reset to 0 on any port-0 grant or idle cycle, and saturate at MAX_BURST; at MAX_BURST a pending p0_req SHALL win.
REQ-011 In a granted cycle, mem_a, mem_wd, mem_we SHALL equal the winner's addr, wdata, we; with no grant mem_we SHALL be 0 and mem_a/mem_wd SHALL hold 0.
REQ-012 A granted read SHALL be returned one cycle later: pX_rdata registered from mem_rd, pX_rvalid=1 for exactly one cycle; rdata holds its value until the next read on that port.
REQ-013 A granted write SHALL NOT assert rvalid.
REQ-014 A requester SHALL hold req/we/addr/wdata stable until gnt; dropping req before gnt withdraws the request with no memory side effect.
REQ-015 Back-to-back grants to one port SHALL be supported, giving one transaction per cycle.
REQ-016 Read in cycle N after write in cycle N-1 to the same address SHALL return the written data.

Reset
REQ-017 On reset low, asynchronously: state=IDLE, last_owner=port 1 (so port 0 wins next), burst_cnt=0, p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
REQ-018 While reset is low, gnt and mem_we SHALL be 0; a read granted in the cycle reset asserts SHALL NOT produce rvalid.
REQ-019 After reset release, the first rising edge SHALL arbitrate normally.

Structure
REQ-020 Shared package SHALL hold the arb_state_t enum (IDLE, GNT0, GNT1) and the port-id type; widths stay as parameters.
REQ-021 No sub-module is required; the round-robin pick with lock and burst rules is one combinational block plus registers.

Verification
REQ-022 Port 0 only, read 0x10 holding 0xDEADBEEF: p0_gnt same cycle; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF.
REQ-023 Both request continuously, no lock: grants alternate p0,p1,p0,p1 starting with p0 after reset.
REQ-024 p1_lock=1, both requesting, MAX_BURST=4: p1 granted 4 cycles, then p0 once, then p1 again.
REQ-025 p1 writes 0x55 to 0x20 in cycle N; p0 reads 0x20 in cycle N+1: p0_rdata=0x55 in cycle N+2.
REQ-026 Reset asserted mid-read grant: rvalid stays 0, mem_we=0 immediately; after release, p0 is granted first when both request.
REQ-027 p1 raises then drops req while p0 holds the grant: no p1_gnt, no memory write at p1_addr.
